// File: rtl/sxr_display_pkg.sv
// Shared types and constants for the sxrRISC621 hex display scanner.
// The segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package sxr_display_pkg;

   typedef logic [6:0] seg_t;

   // Every segment off.
   localparam seg_t SEG_BLANK = 7'h7F;

   // Index is the nibble value; lowercase b and d keep them distinct from 8 and 0.
   localparam seg_t SEG_HEX [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/sxr_hex7seg.sv
// Combinational nibble to active-low 7-segment pattern lookup.
module sxr_hex7seg
   import sxr_display_pkg::*;
(
   input  logic [3:0] nib,
   output seg_t       seg
);

   assign seg = SEG_HEX[nib];

endmodule

// File: rtl/sxr_display_scan.sv
// Time-multiplexed common-anode hex display driver for the core's Display_out bus.
// The input value is latched once per scan frame, so a digit never tears mid-frame.
// Each digit slot opens with one blanked cycle (BLANK) before the anode is
// driven (DRIVE), which suppresses ghosting between neighbouring digits.
// Build option: define LEADING_ZERO_BLANK_EN to switch off leading zero digits
// (digit 0 is always shown).
module sxr_display_scan
   import sxr_display_pkg::*;
#(
   parameter int DIGITS   = 2,
   parameter int SCAN_DIV = 50000
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [4*DIGITS-1:0]   Data_in,
   output seg_t                  Seg_out,
   output logic [DIGITS-1:0]     An_out,
   output logic                  Frame_out
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CNT_W-1:0]          cnt;
   logic [IDX_W-1:0]          idx;
   logic [DIGITS-1:0][3:0]    data_q;
   logic                      drive_q;   // this cycle follows a tick: DRIVE phase
   logic [DIGITS-1:0][6:0]    seg_all;
   logic                      tick;
   logic                      last;
   logic                      blank_dig;

   assign tick = (cnt == CNT_W'(SCAN_DIV - 1));
   assign last = (idx == IDX_W'(DIGITS - 1));

   // One decoder per digit, all fed from the frame-stable latch.
   for (genvar d = 0; d < DIGITS; d++) begin : g_dec
      sxr_hex7seg u_dec (
         .nib (data_q[d]),
         .seg (seg_all[d])
      );
   end

`ifdef LEADING_ZERO_BLANK_EN
   // zero_hi[d]: nibble d and every higher nibble are zero.
   logic [DIGITS-1:0] zero_hi;
   for (genvar d = 0; d < DIGITS; d++) begin : g_zero
      if (d == DIGITS - 1) begin : g_top
         assign zero_hi[d] = (data_q[d] == 4'h0);
      end else begin : g_low
         assign zero_hi[d] = (data_q[d] == 4'h0) && zero_hi[d+1];
      end
   end
   assign blank_dig = (idx != '0) && zero_hi[idx];
`else
   assign blank_dig = 1'b0;
`endif

   // Prescaler, digit index, frame latch and BLANK/DRIVE output registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cnt       <= '0;
         idx       <= IDX_W'(DIGITS - 1);
         data_q    <= '0;
         drive_q   <= 1'b0;
         Seg_out   <= SEG_BLANK;
         An_out    <= '1;
         Frame_out <= 1'b0;
      end else begin
         cnt       <= tick ? '0 : cnt + CNT_W'(1);
         drive_q   <= tick;
         Frame_out <= 1'b0;
         if (tick) begin
            // BLANK: anodes off, segments hold, advance to the next digit.
            idx    <= last ? '0 : idx + IDX_W'(1);
            An_out <= '1;
            if (last) begin
               data_q    <= Data_in;
               Frame_out <= 1'b1;
            end
         end else if (drive_q) begin
            // DRIVE: light the selected digit; outputs hold until the next tick.
            if (blank_dig) begin
               An_out  <= '1;
               Seg_out <= SEG_BLANK;
            end else begin
               An_out  <= ~(DIGITS'(1) << idx);
               Seg_out <= seg_all[idx];
            end
         end
      end
   end

endmodule
